// File: rtl/acc_bridge_pkg.sv
// Shared types and constants for the CPU-to-accelerator offload bridge.
package acc_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StWb
    } acc_state_e;

    // Fill bit replicated across wb_data when a request times out.
    localparam logic ACC_TMO_RESULT = 1'b1;

    localparam int unsigned PERF_W = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/acc_bridge_timer.sv
// Wait-phase timer: clear/enable counter flagging the last allowed WAIT cycle.
module acc_bridge_timer #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // expire fires in the TIMEOUT-th enabled cycle; TIMEOUT of 0 never fires.
    localparam int unsigned TC = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [TMO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (count_q == TMO_W'(TC));

endmodule

// File: rtl/acc_offload_bridge.sv
// CPU-to-accelerator offload bridge: latch operands, issue, stall until done/timeout, one-beat WB.
// Define ACC_BRIDGE_PERF_EN to build the saturating perf_reqs/perf_cycles counters.
module acc_offload_bridge
    import acc_bridge_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_OPS = 2,
    parameter int unsigned RES_W   = 4,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_acc_req,
    input  logic [NUM_OPS*DATA_W-1:0] cpu_ops,
    output logic                      cpu_stall,
    output logic                      wb_valid,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic [NUM_OPS*DATA_W-1:0] acc_ops,
    input  logic                      acc_done,
    input  logic [RES_W-1:0]          acc_result,
    output logic                      err_timeout,
    output logic [PERF_W-1:0]         perf_reqs,
    output logic [PERF_W-1:0]         perf_cycles
);

    acc_state_e                state_q, state_d;
    logic [NUM_OPS*DATA_W-1:0] acc_ops_q, acc_ops_d;
    logic [DATA_W-1:0]         wb_data_q, wb_data_d;
    logic                      err_q, err_d;
    logic                      tmr_clear, tmr_enable, tmr_expire;

    acc_bridge_timer #(
        .TMO_W  (TMO_W),
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .enable(tmr_enable),
        .expire(tmr_expire)
    );

    assign tmr_clear  = (state_q != StWait);
    assign tmr_enable = (state_q == StWait) && !acc_done;

    always_comb begin
        state_d   = state_q;
        acc_ops_d = acc_ops_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        cpu_stall = 1'b0;
        acc_valid = 1'b0;
        wb_valid  = 1'b0;
        case (state_q)
            StIdle: begin
                cpu_stall = cpu_acc_req;
                if (cpu_acc_req) begin
                    acc_ops_d = cpu_ops;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                cpu_stall = 1'b1;
                acc_valid = 1'b1;
                if (acc_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cpu_stall = 1'b1;
                // A real result wins over expiry in the same cycle.
                if (acc_done) begin
                    wb_data_d = DATA_W'(acc_result);
                    state_d   = StWb;
                end else if (tmr_expire) begin
                    wb_data_d = {DATA_W{ACC_TMO_RESULT}};
                    err_d     = 1'b1;
                    state_d   = StWb;
                end
            end
            StWb: begin
                wb_valid = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_ops_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_ops_q <= acc_ops_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign acc_ops     = acc_ops_q;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_q;

`ifdef ACC_BRIDGE_PERF_EN
    logic [PERF_W-1:0] perf_reqs_q, perf_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_reqs_q   <= '0;
            perf_cycles_q <= '0;
        end else begin
            if (state_q == StWb) begin
                perf_reqs_q <= sat_inc(perf_reqs_q);
            end
            if (state_q == StIssue || state_q == StWait) begin
                perf_cycles_q <= sat_inc(perf_cycles_q);
            end
        end
    end

    assign perf_reqs   = perf_reqs_q;
    assign perf_cycles = perf_cycles_q;
`else
    assign perf_reqs   = '0;
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_acc_offload_bridge.sv
// Self-checking bench for acc_offload_bridge against a transaction-level timing/result model.
module tb_acc_offload_bridge;

    localparam int DATA_W  = 16;
    localparam int NUM_OPS = 2;
    localparam int RES_W   = 4;
    localparam int TMO_W   = 8;
    localparam int TMO     = 4;
    localparam int OPS_W   = DATA_W * NUM_OPS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_acc_req = 1'b0;
    logic [OPS_W-1:0]  cpu_ops = '0;
    logic              cpu_stall;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic              acc_valid;
    logic              acc_ready = 1'b0;
    logic [OPS_W-1:0]  acc_ops;
    logic              acc_done = 1'b0;
    logic [RES_W-1:0]  acc_result = '0;
    logic              err_timeout;
    logic [31:0]       perf_reqs;
    logic [31:0]       perf_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state, maintained from stimulus only.
    int exp_reqs   = 0;
    int exp_cycles = 0;
    bit exp_err    = 1'b0;

    acc_offload_bridge #(
        .DATA_W (DATA_W),
        .NUM_OPS(NUM_OPS),
        .RES_W  (RES_W),
        .TMO_W  (TMO_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_acc_req(cpu_acc_req),
        .cpu_ops    (cpu_ops),
        .cpu_stall  (cpu_stall),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_ops    (acc_ops),
        .acc_done   (acc_done),
        .acc_result (acc_result),
        .err_timeout(err_timeout),
        .perf_reqs  (perf_reqs),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycle index (0 = request seen in IDLE) at which wb_valid is expected.
    function automatic int model_lat(input int rdy, input int dn);
        int w;
        w = (dn < TMO) ? dn + 1 : TMO;
        return 1 + (rdy + 1) + w;
    endfunction

    function automatic logic [DATA_W-1:0] model_data(input int dn, input logic [RES_W-1:0] r);
        logic [DATA_W-1:0] v;
        v = '0;
        if (dn < TMO) v[RES_W-1:0] = r;
        else v = '1;
        return v;
    endfunction

    // Drives one ACC transaction: ready after rdy stalled ISSUE cycles, done after dn WAIT cycles.
    task automatic run_txn(input logic [OPS_W-1:0] ops, input int rdy, input int dn,
                           input logic [RES_W-1:0] res, input bit hold,
                           output int wb_cyc, output logic [DATA_W-1:0] wb_d, output int stall_n,
                           output int bad_ops, output int bad_valid, output logic err_wb,
                           output int wb_g);
        int phase;
        int issue_n;
        int wait_n;
        phase = 0; issue_n = 0; wait_n = 0;
        wb_cyc = -1; wb_d = '0; stall_n = 0; bad_ops = 0; bad_valid = 0; err_wb = 1'b0; wb_g = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cpu_acc_req = 1'b1;
                cpu_ops     = ops;
            end else begin
                cpu_acc_req = hold;
                cpu_ops     = OPS_W'($urandom);
            end
            acc_ready = (phase == 1) && (issue_n >= rdy);
            if (phase == 2) acc_done = (wait_n == dn);
            else acc_done = (phase == 1) && !acc_ready && ($urandom_range(0, 1) == 1);
            acc_result = (phase == 2 && acc_done) ? res : RES_W'($urandom);
            #1;
            if (acc_valid !== (phase == 1)) bad_valid++;
            if (phase == 1 && acc_ops !== ops) bad_ops++;
            if (cpu_stall === 1'b1) stall_n++;
            if (wb_valid === 1'b1) begin
                wb_cyc = c;
                wb_d   = wb_data;
                err_wb = err_timeout;
                wb_g   = cyc;
                break;
            end
            if (phase == 0) phase = 1;
            else if (phase == 1) begin
                if (acc_ready) phase = 2;
                issue_n++;
            end else if (phase == 2) begin
                wait_n++;
                if (acc_done || wait_n == TMO) phase = 3;
            end
        end
        cpu_acc_req = 1'b0;
        acc_ready   = 1'b0;
        acc_done    = 1'b0;
        exp_reqs++;
        exp_cycles += model_lat(rdy, dn) - 1;
        if (dn >= TMO) exp_err = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({acc_valid, wb_valid, cpu_stall, err_timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {acc_valid, wb_valid, cpu_stall, err_timeout});
        end
        n_checks++;
        if (acc_ops !== '0 || wb_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: acc_ops=%h wb_data=%h want 0", acc_ops, wb_data);
        end
        n_checks++;
        if (perf_reqs !== 32'd0 || perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: reqs=%0d cycles=%0d want 0", perf_reqs, perf_cycles);
        end
        rst_n = 1'b1;
        exp_reqs = 0; exp_cycles = 0; exp_err = 1'b0;
    endtask

    task automatic test_single();
        int wc, sn, bo, bv, wg;
        logic [DATA_W-1:0] wd;
        logic ew;
        run_txn({16'h0012, 16'h0034}, 0, 0, 4'h7, 1'b1, wc, wd, sn, bo, bv, ew, wg);
        n_checks++;
        if (wc !== 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want 3", wc);
        end
        n_checks++;
        if (wd !== 16'h0007) begin
            n_fail++;
            $display("FAIL single_data: got %h want 0007", wd);
        end
        n_checks++;
        if (sn !== 3 || bo !== 0 || bv !== 0) begin
            n_fail++;
            $display("FAIL single_handshake: stall=%0d want 3, bad_ops=%0d bad_valid=%0d want 0", sn, bo, bv);
        end
    endtask

    task automatic test_backpressure();
        int wc, sn, bo, bv, wg;
        logic [DATA_W-1:0] wd;
        logic ew;
        run_txn(32'hA5A5_5A5A, 5, 1, 4'hC, 1'b0, wc, wd, sn, bo, bv, ew, wg);
        n_checks++;
        if (wc !== model_lat(5, 1) || sn !== model_lat(5, 1)) begin
            n_fail++;
            $display("FAIL bp_latency: wb=%0d stall=%0d want %0d", wc, sn, model_lat(5, 1));
        end
        n_checks++;
        if (bo !== 0 || bv !== 0 || wd !== model_data(1, 4'hC)) begin
            n_fail++;
            $display("FAIL bp_ops: bad_ops=%0d bad_valid=%0d data=%h want 0 0 %h", bo, bv, wd, model_data(1, 4'hC));
        end
    endtask

    task automatic test_timeout();
        int wc, sn, bo, bv, wg;
        logic [DATA_W-1:0] wd;
        logic ew;
        run_txn(32'h1234_5678, 1, 1000, 4'h2, 1'b1, wc, wd, sn, bo, bv, ew, wg);
        n_checks++;
        if (wc !== 1 + 2 + TMO || wd !== 16'hFFFF || ew !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_wb: wb=%0d data=%h err=%b want %0d FFFF 1", wc, wd, ew, 1 + 2 + TMO);
        end
        // A late done landing in IDLE must not produce a write-back.
        @(negedge clk);
        acc_done = 1'b1;
        acc_result = 4'h5;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL late_done: wb_valid=%b stall=%b want 0 0", wb_valid, cpu_stall);
        end
        @(negedge clk);
        acc_done = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || wb_data !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL late_done_hold: wb_valid=%b data=%h want 0 FFFF", wb_valid, wb_data);
        end
        run_txn(32'h0BAD_F00D, 0, 2, 4'h6, 1'b0, wc, wd, sn, bo, bv, ew, wg);
        n_checks++;
        if (wd !== 16'h0006 || ew !== 1'b1 || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: data=%h err=%b/%b want 0006 1", wd, ew, err_timeout);
        end
    endtask

    task automatic test_back_to_back();
        int wc1, wc2, sn, bo, bv, wg1, wg2;
        logic [DATA_W-1:0] wd1, wd2;
        logic ew;
        run_txn(32'h0001_0002, 0, 0, 4'h3, 1'b1, wc1, wd1, sn, bo, bv, ew, wg1);
        run_txn(32'h0003_0004, 0, 0, 4'h9, 1'b1, wc2, wd2, sn, bo, bv, ew, wg2);
        n_checks++;
        if (wd1 !== 16'h0003 || wd2 !== 16'h0009) begin
            n_fail++;
            $display("FAIL b2b_order: got %h,%h want 0003,0009", wd1, wd2);
        end
        n_checks++;
        if (wc1 !== 3 || wc2 !== 3 || (wg2 - wg1) !== 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: lat %0d,%0d gap %0d want 3,3 gap 4", wc1, wc2, wg2 - wg1);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse: wb_valid=%b want 0 after WB", wb_valid);
        end
    endtask

    task automatic test_reset_wait();
        int wc, sn, bo, bv, wg, seen_wb;
        logic [DATA_W-1:0] wd;
        logic ew;
        @(negedge clk);
        cpu_acc_req = 1'b1;
        cpu_ops = 32'hCAFE_BEEF;
        @(negedge clk);
        cpu_acc_req = 1'b0;
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc_valid, wb_valid, cpu_stall, err_timeout} !== 4'b0000 || acc_ops !== '0) begin
            n_fail++;
            $display("FAIL rst_wait_flags: got %b ops=%h want 0000 0", {acc_valid, wb_valid, cpu_stall, err_timeout}, acc_ops);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_reqs = 0; exp_cycles = 0; exp_err = 1'b0;
        seen_wb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc_done = (i == 0);
            acc_result = 4'hA;
            #1;
            if (wb_valid !== 1'b0 || cpu_stall !== 1'b0 || acc_valid !== 1'b0) seen_wb++;
        end
        acc_done = 1'b0;
        n_checks++;
        if (seen_wb !== 0) begin
            n_fail++;
            $display("FAIL rst_wait_idle: %0d active cycles want 0", seen_wb);
        end
        run_txn(32'h0055_00AA, 1, 0, 4'hB, 1'b0, wc, wd, sn, bo, bv, ew, wg);
        n_checks++;
        if (wc !== model_lat(1, 0) || wd !== 16'h000B || ew !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_recover: wb=%0d data=%h err=%b want %0d 000B 0", wc, wd, ew, model_lat(1, 0));
        end
    endtask

    task automatic test_random();
        int wc, sn, bo, bv, wg, rdy, dn;
        logic [DATA_W-1:0] wd;
        logic [RES_W-1:0] res;
        logic [OPS_W-1:0] ops;
        logic ew;
        for (int i = 0; i < 24; i++) begin
            ops = OPS_W'($urandom);
            rdy = $urandom_range(0, 3);
            dn  = $urandom_range(0, 5);
            res = RES_W'($urandom);
            run_txn(ops, rdy, dn, res, bit'($urandom_range(0, 1)), wc, wd, sn, bo, bv, ew, wg);
            n_checks++;
            if (wc !== model_lat(rdy, dn) || sn !== model_lat(rdy, dn)) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: wb=%0d stall=%0d want %0d", i, wc, sn, model_lat(rdy, dn));
            end
            n_checks++;
            if (wd !== model_data(dn, res) || ew !== exp_err || bo !== 0 || bv !== 0) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: data=%h err=%b bo=%0d bv=%0d want %h %b 0 0",
                         i, wd, ew, bo, bv, model_data(dn, res), exp_err);
            end
        end
    endtask

    task automatic test_perf();
        int wc, sn, bo, bv, wg;
        logic [DATA_W-1:0] wd;
        logic ew;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_reqs = 0; exp_cycles = 0; exp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_txn(OPS_W'($urandom), 2, 0, RES_W'(i), 1'b0, wc, wd, sn, bo, bv, ew, wg);
        end
        @(negedge clk);
        #1;
`ifdef ACC_BRIDGE_PERF_EN
        n_checks++;
        if (perf_reqs !== 32'(exp_reqs) || perf_cycles !== 32'(exp_cycles)) begin
            n_fail++;
            $display("FAIL perf_counts: reqs=%0d cycles=%0d want %0d %0d", perf_reqs, perf_cycles, exp_reqs, exp_cycles);
        end
`else
        n_checks++;
        if (perf_reqs !== 32'd0 || perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_tied: reqs=%0d cycles=%0d want 0 0", perf_reqs, perf_cycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_wait();
        test_random();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
